// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage.
//   fetch_state_e  : fetch FSM state encoding
//   BUBBLE_INSTR   : instruction word loaded into F/D for a bubble
//   PC_STEP        : byte distance between consecutive instructions
//   PC_READ_OFFSET : offset of the R15 read value from the instruction address
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] BUBBLE_INSTR   = 32'h0000_0000;
    localparam int unsigned PC_STEP        = 4;
    localparam int unsigned PC_READ_OFFSET = 8;

endpackage

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Fetch FSM: owns the request address, the pending redirect target and a
// one-entry hold buffer for an instruction that arrives while fetch is stalled.
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   stall_f            hold fetch (no delivery towards D)
//   redir, target      redirect request and its (already prioritised) target
//   imem_req/addr      request to instruction memory
//   imem_ack/rdata     response from instruction memory
//   deliver            strobe: an instruction is handed to D this cycle
//   deliver_instr/addr the handed-over instruction and its address
// -----------------------------------------------------------------------------
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned     WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_f,
    input  logic             redir,
    input  logic [WIDTH-1:0] target,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             deliver,
    output logic [WIDTH-1:0] deliver_instr,
    output logic [WIDTH-1:0] deliver_addr
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(PC_STEP);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] req_addr_q, req_addr_d;
    logic [WIDTH-1:0] redir_pc_q, redir_pc_d;
    logic [WIDTH-1:0] buf_instr_q, buf_instr_d;
    logic [WIDTH-1:0] buf_addr_q, buf_addr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            req_addr_q  <= RESET_PC;
            redir_pc_q  <= '0;
            buf_instr_q <= '0;
            buf_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            redir_pc_q  <= redir_pc_d;
            buf_instr_q <= buf_instr_d;
            buf_addr_q  <= buf_addr_d;
        end
    end

    // The request address is held while a request is outstanding, so the
    // address output is simply the register.
    assign imem_addr = req_addr_q;

    always_comb begin
        state_d       = state_q;
        req_addr_d    = req_addr_q;
        redir_pc_d    = redir_pc_q;
        buf_instr_d   = buf_instr_q;
        buf_addr_d    = buf_addr_q;
        imem_req      = 1'b0;
        deliver       = 1'b0;
        deliver_instr = imem_rdata;
        deliver_addr  = req_addr_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                if (redir) begin
                    req_addr_d = target;
                end
            end

            ST_REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (redir) begin
                        // Returned word is on the wrong path: drop it.
                        req_addr_d = target;
                    end else if (!stall_f) begin
                        deliver    = 1'b1;
                        req_addr_d = req_addr_q + STEP;
                    end else begin
                        buf_instr_d = imem_rdata;
                        buf_addr_d  = req_addr_q;
                        state_d     = ST_HOLD;
                    end
                end else if (redir) begin
                    // The request must still complete; remember where to go.
                    redir_pc_d = target;
                    state_d    = ST_DRAIN;
                end
            end

            ST_HOLD: begin
                if (redir) begin
                    req_addr_d = target;
                    state_d    = ST_REQ;
                end else if (!stall_f) begin
                    deliver       = 1'b1;
                    deliver_instr = buf_instr_q;
                    deliver_addr  = buf_addr_q;
                    req_addr_d    = buf_addr_q + STEP;
                    state_d       = ST_REQ;
                end
            end

            ST_DRAIN: begin
                imem_req = 1'b1;
                if (redir) begin
                    redir_pc_d = target;
                end
                if (imem_ack) begin
                    // A redirect in the ack cycle is newer than the stored one.
                    req_addr_d = redir ? target : redir_pc_q;
                    state_d    = ST_REQ;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: prioritises redirects, runs the fetch controller and
// holds the F/D pipeline register feeding decode.
// Ports:
//   clk, reset               clock, asynchronous active-low reset
//   StallF, StallD, FlushD   hazard-unit controls
//   BranchTakenE/ALUResultE  branch redirect from Execute (higher priority)
//   PCSrcW/ResultW           PC-write redirect from Writeback
//   imem_*                   req/ack instruction-memory port
//   InstrD, PCPlus8D, ValidD registered F/D outputs
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             BranchTakenE,
    input  logic [WIDTH-1:0] ALUResultE,
    input  logic             PCSrcW,
    input  logic [WIDTH-1:0] ResultW,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] InstrD,
    output logic [WIDTH-1:0] PCPlus8D,
    output logic             ValidD
);

    localparam logic [WIDTH-1:0] READ_OFS = WIDTH'(PC_READ_OFFSET);
    localparam logic [WIDTH-1:0] BUBBLE   = WIDTH'(BUBBLE_INSTR);

    logic             redir;
    logic [WIDTH-1:0] target;
    logic             deliver;
    logic [WIDTH-1:0] deliver_instr;
    logic [WIDTH-1:0] deliver_addr;

    logic [WIDTH-1:0] fd_instr_q, fd_instr_d;
    logic [WIDTH-1:0] fd_pc8_q, fd_pc8_d;
    logic             fd_valid_q, fd_valid_d;

    // Execute-stage branch is younger than the Writeback PC write, so it wins.
    assign redir  = BranchTakenE | PCSrcW;
    assign target = BranchTakenE ? ALUResultE : ResultW;

    fetch_ctrl #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) u_ctrl (
        .clk           (clk),
        .reset         (reset),
        .stall_f       (StallF),
        .redir         (redir),
        .target        (target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .deliver       (deliver),
        .deliver_instr (deliver_instr),
        .deliver_addr  (deliver_addr)
    );

    always_comb begin
        fd_instr_d = fd_instr_q;
        fd_pc8_d   = fd_pc8_q;
        fd_valid_d = fd_valid_q;
        if (FlushD) begin
            fd_instr_d = BUBBLE;
            fd_pc8_d   = '0;
            fd_valid_d = 1'b0;
        end else if (!StallD) begin
            if (deliver) begin
                fd_instr_d = deliver_instr;
                fd_pc8_d   = deliver_addr + READ_OFS;
                fd_valid_d = 1'b1;
            end else begin
                fd_instr_d = BUBBLE;
                fd_pc8_d   = '0;
                fd_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fd_instr_q <= BUBBLE;
            fd_pc8_q   <= '0;
            fd_valid_q <= 1'b0;
        end else begin
            fd_instr_q <= fd_instr_d;
            fd_pc8_q   <= fd_pc8_d;
            fd_valid_q <= fd_valid_d;
        end
    end

    assign InstrD   = fd_instr_q;
    assign PCPlus8D = fd_pc8_q;
    assign ValidD   = fd_valid_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined core: owns the fetch PC, talks to instruction memory over a req/ack handshake of variable latency, and loads the F/D pipeline register that feeds the decode-stage controller (`InstrD`). It applies redirects from a taken branch in Execute (`BranchTakenE`) and from a PC write in Writeback (`PCSrcW`). It obeys the hazard unit's `StallF`, `StallD` and `FlushD`, and inserts bubbles whenever memory has not yet returned an instruction.

## Interface
- `WIDTH`, 32, data and address width.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `StallF`  in  1  hold fetch; no new instruction is accepted into D from F.
- `StallD`  in  1  hold the F/D register.
- `FlushD`  in  1  load a bubble into F/D.
- `BranchTakenE`  in  1  redirect to `ALUResultE`.
- `ALUResultE`  in  WIDTH  branch target.
- `PCSrcW`  in  1  redirect to `ResultW`.
- `ResultW`  in  WIDTH  PC-write target.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  WIDTH  fetch address; word-aligned.
- `imem_ack`  in  1  `imem_rdata` is valid for the current request.
- `imem_rdata`  in  WIDTH  instruction word.
- `InstrD`  out  WIDTH  decode-stage instruction.
- `PCPlus8D`  out  WIDTH  address of `InstrD` + 8; the R15 read value.
- `ValidD`  out  1  `InstrD` is a real instruction. The hazard unit asserts `FlushE` when this is 0.

## Operation
- **Registers**
  - `ReqAddr`: current or next request address.
  - `RedirPC`: pending redirect target.
  - `BufInstr` and `BufAddr`: one-entry hold buffer.
  - FSM state.
  - F/D register: `InstrD`, `PCPlus8D`, `ValidD`.
- **Redirect**
  - `Redir` = `BranchTakenE | PCSrcW`.
  - `Target` = `BranchTakenE ? ALUResultE : ResultW`. `BranchTakenE` has priority.
- **IDLE**
  - `imem_req` = 0.
  - Always moves to REQ on the next cycle.
  - If `Redir`, set `ReqAddr` = `Target`.
- **REQ**
  - `imem_req` = 1, `imem_addr` = `ReqAddr`. `ReqAddr` is stable while the request is unacked.
  - ack & `Redir`: drop the data; `ReqAddr` ← `Target`; stay in REQ.
  - ack & !`Redir` & !`StallF`: deliver `imem_rdata` to D; `ReqAddr` ← `ReqAddr`+4; stay in REQ.
  - ack & !`Redir` & `StallF`: `BufInstr` ← `imem_rdata`, `BufAddr` ← `ReqAddr`; go to HOLD.
  - !ack & `Redir`: `RedirPC` ← `Target`; go to DRAIN.
- **HOLD**
  - `imem_req` = 0.
  - `Redir`: discard the buffer; `ReqAddr` ← `Target`; go to REQ.
  - Else, !`StallF`: deliver `BufInstr`; `ReqAddr` ← `BufAddr`+4; go to REQ.
- **DRAIN**
  - `imem_req` = 1 with the old address, kept until ack.
  - `Redir` again: `RedirPC` ← the newest `Target`.
  - On ack: drop the data; `ReqAddr` ← the `Redir` ? `Target` : `RedirPC`; go to REQ.
- **F/D register update**, priority order:
  1. `FlushD`: bubble.
  2. `StallD`: hold.
  3. Otherwise: load the delivered instruction with `ValidD`=1 and `PCPlus8D` = its address + 8, or a bubble if nothing is delivered this cycle.
- **Bubble**: `InstrD` = `BUBBLE_INSTR` (0), `PCPlus8D` = 0, `ValidD` = 0.
- **Stall/delivery agreement**: the hazard unit asserts `StallD` only together with `StallF`, so delivery never overwrites a held D.
- **Arithmetic**: addresses wrap modulo 2^WIDTH; 32'hFFFF_FFFC + 4 = 0.

## Timing
- **Reset** (asynchronous, `reset`=0):
  - state IDLE; `ReqAddr` = `RESET_PC`; `RedirPC` = 0; buffer = 0.
  - `imem_req` = 0; `imem_addr` = `RESET_PC`.
  - `InstrD` = 0; `PCPlus8D` = 0; `ValidD` = 0.
- **After reset release**: first `imem_req` = 1 one cycle after the first rising edge.
- **Latency**:
  - Ack in cycle n gives `InstrD` valid after edge n→n+1.
  - With ack tied to 1, throughput is one instruction per cycle.
- **Redirect**: a redirect asserted in cycle n with no outstanding request puts the target on `imem_addr` in cycle n+1.
- **Reset mid-request**: abandons the request. Memory must tolerate `imem_req` dropping without ack.
- **All outputs are registered** except `imem_addr` and `imem_req`, which are decoded from state and registers. There is no combinational path from inputs to outputs.

## Structure
- **Shared package / include**:
  - FSM state encodings: IDLE=2'd0, REQ=2'd1, HOLD=2'd2, DRAIN=2'd3.
  - `BUBBLE_INSTR` = 32'h0.
  - `PC_STEP` = 4.
  - `PC_READ_OFFSET` = 8.
- **Sub-module**: `fetch_ctrl`, containing the FSM, `ReqAddr`, `RedirPC` and the buffer. It outputs the deliver strobe, delivered instruction and delivered address.
- **Top level**: `fetch_stage` holds the F/D register and the redirect mux.

## Test plan
- **Reset and streaming**: reset, memory with ack always 1 and rdata = addr ^ 32'hE000_0000 → `imem_addr` 0, 4, 8 on consecutive cycles; `InstrD` = 32'hE000_0000, then 32'hE000_0004; `PCPlus8D` 8, 12; `ValidD`=1.
- **Wait states**: ack delayed 3 cycles per request → `imem_addr` holds 0 for 3 cycles; D receives 3 bubbles (`ValidD`=0), then the instruction.
- **Redirect in flight**: `BranchTakenE`=1 with `ALUResultE`=32'h100 while the request at 8 is unacked → DRAIN; the data from 8 is dropped; the next request is 32'h100. Also assert `PCSrcW` in the same cycle with `ResultW`=32'h200 → 32'h100 still wins.
- **Stall with buffer**: `StallF`=`StallD`=1 for 2 cycles at the ack of 32'h10 → HOLD with `imem_req`=0. After release, D gets the 32'h10 instruction; the next request is 32'h14.
- **Flush vs stall**: `FlushD`=1 and `StallD`=1 together → `ValidD`=0, `InstrD`=0.
- **Wrap-around and mid-operation reset**: `RESET_PC`=32'hFFFF_FFFC → second request at 0. Assert `reset`=0 mid-DRAIN → all outputs return to reset values immediately.
